// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the multi-cycle MIPS control, MIPS_ALU and
// the datapath.
//   - opcode (IR[31:26]) and R-type funct (IR[5:0]) values
//   - ALUControl codes driven into MIPS_ALU (ALU_INVALID = 4'b1111)
//   - ALUOp encoding between the main FSM and mips_alu_decoder
//   - main FSM state encodings
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_NOR     = 4'b1100;
  localparam logic [3:0] ALU_INVALID = 4'b1111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

endpackage

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: combinational ALU decoder.
//   alu_op_i [1:0]  00=ADD, 01=SUB, 10=decode from funct_i, 11=invalid
//   funct_i  [5:0]  IR[5:0]
//   alu_ctl_o[3:0]  ALUControl to MIPS_ALU
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctl_o
);

  always_comb begin
    alu_ctl_o = ALU_INVALID;
    case (alu_op_i)
      ALUOP_ADD: alu_ctl_o = ALU_ADD;
      ALUOP_SUB: alu_ctl_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alu_ctl_o = ALU_ADD;
          FN_SUB:  alu_ctl_o = ALU_SUB;
          FN_AND:  alu_ctl_o = ALU_AND;
          FN_OR:   alu_ctl_o = ALU_OR;
          FN_SLT:  alu_ctl_o = ALU_SLT;
          FN_NOR:  alu_ctl_o = ALU_NOR;
          default: alu_ctl_o = ALU_INVALID;
        endcase
      end
      default: alu_ctl_o = ALU_INVALID;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multi-cycle MIPS main control FSM (Moore).
// Decodes Op/Funct from the IR and sequences the shared datapath.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   Op, Funct       IR[31:26], IR[5:0]
//   Zero            MIPS_ALU zero flag (used in BRANCH)
//   IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//   ALUSrcA, ALUSrcB, PCSrc, PCEn   datapath controls
//   ALUControl      to MIPS_ALU, via mips_alu_decoder
//   State           current state, debug only
// Build option: MIPS_MC_ADDI_EN adds the ADDIEX/ADDIWB states for addi;
// without it addi is treated as an unknown opcode.
//
// state   | meaning
// --------+---------------------------------------------
// FETCH   | read mem[PC] into IR, PC <= PC+4
// DECODE  | read regs, ALUOut <= branch target, dispatch on Op
// MEMADR  | ALUOut <= regA + SignImm (lw/sw address)
// MEMRD   | MDR <= mem[ALUOut]
// MEMWB   | rt <= MDR
// MEMWR   | mem[ALUOut] <= regB
// EXECUTE | R-type ALU operation from Funct
// ALUWB   | rd <= ALUOut
// BRANCH  | regA - regB, PC <= ALUOut if Zero
// ADDIEX  | regA + SignImm (MIPS_MC_ADDI_EN only)
// ADDIWB  | rt <= ALUOut  (MIPS_MC_ADDI_EN only)
// JUMP    | PC <= jump target
// 12..15  | illegal: enables 0, return to FETCH
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic               PCEn,
  output logic [3:0]         ALUControl,
  output logic [STATE_W-1:0] State
);

  logic [3:0] state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_write, branch, mem_write, ir_write, reg_write;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = S_FETCH;
    alu_op    = ALUOP_ADD;
    IorD      = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    reg_write = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    PCSrc     = 2'b00;
    pc_write  = 1'b0;
    branch    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        ALUSrcB  = 2'b01;
        pc_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_MC_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg  = 1'b1;
        reg_write = 1'b1;
      end
      S_MEMWR: begin
        IorD      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst    = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_SUB;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
`ifdef MIPS_MC_ADDI_EN
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
`endif
      S_JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write enables are masked combinationally so a reset landing mid-instruction
  // blocks the write in the same cycle, not one cycle later.
  assign MemWrite = mem_write & ~reset;
  assign IRWrite  = ir_write  & ~reset;
  assign RegWrite = reg_write & ~reset;
  assign PCEn     = (pc_write | (branch & Zero)) & ~reset;
  assign State    = STATE_W'(state_q);

  mips_alu_decoder u_alu_dec (
    .alu_op_i  (alu_op),
    .funct_i   (Funct),
    .alu_ctl_o (ALUControl)
  );

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op, Funct;
  logic       Zero;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] ALUControl, State;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .PCEn(PCEn),
    .ALUControl(ALUControl), .State(State)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int iord, memwrite, irwrite, regdst, memtoreg, regwrite;
    int srca, srcb, pcsrc, pcen, alu;  // alu = -1 where not specified
  } out_t;

  function automatic int funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      6'b100111: return 12;
      default:   return 15;
    endcase
  endfunction

  function automatic out_t model_out(input int s, input logic [5:0] f, input logic z);
    out_t o = '{default: 0};
    o.alu = -1;
    case (s)
      0:  begin o.irwrite = 1; o.srcb = 1; o.alu = 2; o.pcen = 1; end
      1:  begin o.srcb = 3; o.alu = 2; end
      2:  begin o.srca = 1; o.srcb = 2; o.alu = 2; end
      3:  o.iord = 1;
      4:  begin o.memtoreg = 1; o.regwrite = 1; end
      5:  begin o.iord = 1; o.memwrite = 1; end
      6:  begin o.srca = 1; o.alu = funct_alu(f); end
      7:  begin o.regdst = 1; o.regwrite = 1; end
      8:  begin o.srca = 1; o.alu = 6; o.pcsrc = 1; o.pcen = int'(z); end
      9:  begin o.srca = 1; o.srcb = 2; o.alu = 2; end
      10: o.regwrite = 1;
      11: begin o.pcsrc = 2; o.pcen = 1; end
      default: ;
    endcase
    return o;
  endfunction

  int seq_q[$];

  function automatic void model_seq(input logic [5:0] op);
    seq_q.delete();
    seq_q.push_back(0);
    seq_q.push_back(1);
    case (op)
      6'b100011: begin seq_q.push_back(2); seq_q.push_back(3); seq_q.push_back(4); end
      6'b101011: begin seq_q.push_back(2); seq_q.push_back(5); end
      6'b000000: begin seq_q.push_back(6); seq_q.push_back(7); end
      6'b000100: seq_q.push_back(8);
`ifdef MIPS_MC_ADDI_EN
      6'b001000: begin seq_q.push_back(9); seq_q.push_back(10); end
`endif
      6'b000010: seq_q.push_back(11);
      default: ;
    endcase
  endfunction

  task automatic cmp_outputs(input int s);
    out_t e = model_out(s, Funct, Zero);
    chk($sformatf("st%0d IorD", s),     int'(IorD),     e.iord);
    chk($sformatf("st%0d MemWrite", s), int'(MemWrite), e.memwrite);
    chk($sformatf("st%0d IRWrite", s),  int'(IRWrite),  e.irwrite);
    chk($sformatf("st%0d RegDst", s),   int'(RegDst),   e.regdst);
    chk($sformatf("st%0d MemtoReg", s), int'(MemtoReg), e.memtoreg);
    chk($sformatf("st%0d RegWrite", s), int'(RegWrite), e.regwrite);
    chk($sformatf("st%0d ALUSrcA", s),  int'(ALUSrcA),  e.srca);
    chk($sformatf("st%0d ALUSrcB", s),  int'(ALUSrcB),  e.srcb);
    chk($sformatf("st%0d PCSrc", s),    int'(PCSrc),    e.pcsrc);
    chk($sformatf("st%0d PCEn", s),     int'(PCEn),     e.pcen);
    if (e.alu >= 0) chk($sformatf("st%0d ALUControl", s), int'(ALUControl), e.alu);
  endtask

  // Starts at a negedge with State expected FETCH; ends at the negedge
  // where the DUT is back in FETCH (or the cycle bound expires).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int exp_cycles, input int exp_exec_alu);
    int cyc = 0;
    Op = op; Funct = fn; Zero = z;
    model_seq(op);
    #1;
    do begin
      if (cyc < seq_q.size()) begin
        chk($sformatf("op%b state[%0d]", op, cyc), int'(State), seq_q[cyc]);
        cmp_outputs(seq_q[cyc]);
      end
      if (State == 4'd6 && exp_exec_alu >= 0)
        chk($sformatf("funct%b exec ALUControl", fn), int'(ALUControl), exp_exec_alu);
      if (State != 4'd10 && State != 4'd4 && State != 4'd7)
        chk($sformatf("op%b no RegWrite st%0d", op, State), int'(RegWrite), 0);
      @(posedge clk); @(negedge clk); #1;
      cyc++;
    end while (State != 4'd0 && cyc < 12);
    chk($sformatf("op%b cycles", op), cyc, exp_cycles);
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         cycles;
    int         exec_alu;
  } vec_t;

  vec_t vecs[$];
  logic [5:0] ops[7];
  logic [5:0] fns[7];

  initial begin
    int addi_cyc;
`ifdef MIPS_MC_ADDI_EN
    addi_cyc = 4;
`else
    addi_cyc = 2;
`endif
    vecs.push_back('{6'b100011, 6'b000000, 1'b0, 5, -1});
    vecs.push_back('{6'b101011, 6'b000000, 1'b0, 4, -1});
    vecs.push_back('{6'b000000, 6'b100000, 1'b0, 4, 4'b0010});
    vecs.push_back('{6'b000000, 6'b100010, 1'b0, 4, 4'b0110});
    vecs.push_back('{6'b000000, 6'b100100, 1'b0, 4, 4'b0000});
    vecs.push_back('{6'b000000, 6'b100101, 1'b0, 4, 4'b0001});
    vecs.push_back('{6'b000000, 6'b101010, 1'b0, 4, 4'b0111});
    vecs.push_back('{6'b000000, 6'b100111, 1'b0, 4, 4'b1100});
    vecs.push_back('{6'b000000, 6'b111111, 1'b0, 4, 4'b1111});
    vecs.push_back('{6'b000100, 6'b000000, 1'b1, 3, -1});
    vecs.push_back('{6'b000100, 6'b000000, 1'b0, 3, -1});
    vecs.push_back('{6'b001000, 6'b000000, 1'b0, addi_cyc, -1});
    vecs.push_back('{6'b000010, 6'b000000, 1'b0, 3, -1});
    vecs.push_back('{6'b111111, 6'b000000, 1'b0, 2, -1});
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b110011};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b000111};

    // Reset for two cycles.
    reset = 1'b1; Op = 6'b100011; Funct = 6'b0; Zero = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk); #1;
      chk("reset State", int'(State), 0);
      chk("reset MemWrite", int'(MemWrite), 0);
      chk("reset IRWrite", int'(IRWrite), 0);
      chk("reset RegWrite", int'(RegWrite), 0);
      chk("reset PCEn", int'(PCEn), 0);
    end
    reset = 1'b0; #1;
    chk("post-reset PCEn", int'(PCEn), 1);
    chk("post-reset IRWrite", int'(IRWrite), 1);
    chk("post-reset ALUControl", int'(ALUControl), 2);

    foreach (vecs[i])
      run_instr(vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].cycles, vecs[i].exec_alu);

    // Reset arriving in MEMWR must suppress the store in that same cycle.
    Op = 6'b101011; Funct = 6'b0; Zero = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); @(negedge clk); end
    #1;
    chk("sw reaches MEMWR", int'(State), 5);
    chk("MEMWR MemWrite pre-reset", int'(MemWrite), 1);
    reset = 1'b1; #1;
    chk("MEMWR MemWrite under reset", int'(MemWrite), 0);
    @(posedge clk); @(negedge clk); #1;
    chk("State after MEMWR reset", int'(State), 0);
    chk("IRWrite under reset", int'(IRWrite), 0);
    reset = 1'b0; #1;

    // Randomized instruction stream against the model.
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op, fn;
      logic z;
      op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 6)] : 6'($urandom);
      fn = ($urandom_range(0, 9) < 8) ? fns[$urandom_range(0, 6)] : 6'($urandom);
      z  = 1'($urandom);
      model_seq(op);
      run_instr(op, fn, z, seq_q.size(), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
